exc_unit: RTL and testbench

- Pipeline-side exception controller; the producer end of the coprocessor 0 exception interface.
- Collects exception flags from the ID/EX/MEM stages and the external interrupt line, and selects the oldest one.
- Sends exactly one single-cycle int_* pulse with EPC/BadVAddr to coprocessor 0, flushes the pipeline, then redirects fetch to the kernel handler. Also sequences ERET redirects.

---
 rtl/exc_unit_pkg.sv | 46 ++++
 rtl/exc_unit_sync.sv | 22 ++
 rtl/exc_unit.sv | 212 +++++++++++++++++++++
 tb/tb_exc_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_unit_pkg.sv
// exc_unit shared types: FSM states, handler vector,
// cause one-hot bundle and CP0 ExcCode values.
package exc_unit_pkg;

  typedef enum logic [1:0] {
    EXU_IDLE     = 2'd0,
    EXU_RAISE    = 2'd1,
    EXU_FLUSH    = 2'd2,
    EXU_REDIRECT = 2'd3
  } exu_state_e;

  localparam logic [31:0] EXU_HANDLER = 32'h8000_0180;

  typedef enum logic [4:0] {
    INT_EXT   = 5'd0,
    INT_ADDRL = 5'd4,
    INT_ADDRS = 5'd5,
    INT_SYS   = 5'd8,
    INT_RI    = 5'd10,
    INT_OVF   = 5'd12,
    INT_TR    = 5'd13
  } exu_code_e;

  typedef struct packed {
    logic ext;
    logic tr;
    logic ovf;
    logic ri;
    logic sys;
    logic addrs;
    logic addrl;
  } exu_cause_t;

  function automatic exu_code_e cause_code(
    input exu_cause_t c
  );
    if (c.addrs)      return INT_ADDRS;
    else if (c.addrl) return INT_ADDRL;
    else if (c.tr)    return INT_TR;
    else if (c.ovf)   return INT_OVF;
    else if (c.ri)    return INT_RI;
    else if (c.sys)   return INT_SYS;
    else              return INT_EXT;
  endfunction

endpackage

// File: rtl/exc_unit_sync.sv
// sync_ff: flop chain bringing an async level
// into the clk domain; cleared by async reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the async level through the chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/exc_unit.sv
// exc_unit: picks the oldest pending exception,
// pulses CP0 once, flushes, then redirects fetch.
module exc_unit
  import exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = EXU_HANDLER,
  parameter int          FLUSH_CYCLES = 3,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic [31:0] id_pc,
  input  logic        ex_tr,
  input  logic        ex_ovf,
  input  logic [31:0] ex_pc,
  input  logic        mem_addrs,
  input  logic        mem_addrl,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_addr,
  input  logic        mem_eret,
  input  logic        exc_level,
  input  logic [31:0] epc_in,
  output logic        int_ext,
  output logic        int_tr,
  output logic        int_ovf,
  output logic        int_ri,
  output logic        int_sys,
  output logic        int_addrs,
  output logic        int_addrl,
  output logic [31:0] epc_out,
  output logic [31:0] badvaddr_out,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        double_fault
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(FLUSH_CYCLES - 1);

  exu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  exu_cause_t  cause_q, cause_d;
  exu_cause_t  sel;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bad_q, bad_d;
  logic [31:0] sel_pc;
  logic        eret_q, eret_d;
  logic        pend_q;
  logic        df_q;
  logic        ext_s;
  logic        go_exc;
  logic        go_eret;
  logic        drop;
  logic        take_ext;
  logic        younger;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (ext_irq),
    .q    (ext_s)
  );

  assign younger = ex_tr | ex_ovf | id_ri | id_sys;

  // oldest-first arbitration among the stage flags
  always_comb begin
    sel     = '0;
    sel_pc  = '0;
    go_exc  = 1'b0;
    go_eret = 1'b0;
    drop    = 1'b0;
    if (state_q == EXU_IDLE) begin
      if (exc_level) begin
        if (mem_addrs | mem_addrl) drop = 1'b1;
        else if (mem_eret)         go_eret = 1'b1;
        else if (younger)          drop = 1'b1;
      end else begin
        go_exc = 1'b1;
        if (mem_addrs) begin
          sel.addrs = 1'b1;
          sel_pc    = mem_pc;
        end else if (mem_addrl) begin
          sel.addrl = 1'b1;
          sel_pc    = mem_pc;
        end else if (mem_eret) begin
          go_exc  = 1'b0;
          go_eret = 1'b1;
        end else if (ex_tr) begin
          sel.tr = 1'b1;
          sel_pc = ex_pc;
        end else if (ex_ovf) begin
          sel.ovf = 1'b1;
          sel_pc  = ex_pc;
        end else if (id_ri) begin
          sel.ri = 1'b1;
          sel_pc = id_pc;
        end else if (id_sys) begin
          sel.sys = 1'b1;
          sel_pc  = id_pc;
        end else if (pend_q) begin
          sel.ext = 1'b1;
          sel_pc  = mem_pc;
        end else begin
          go_exc = 1'b0;
        end
      end
    end
  end

  assign take_ext = go_exc & sel.ext;

  // next-state and capture values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    bad_d   = bad_q;
    eret_d  = eret_q;
    unique case (state_q)
      EXU_IDLE: begin
        if (go_exc) begin
          state_d = EXU_RAISE;
          cause_d = sel;
          epc_d   = sel_pc;
          bad_d   = (sel.addrs | sel.addrl)
                    ? mem_addr : '0;
          eret_d  = 1'b0;
        end else if (go_eret) begin
          state_d = EXU_FLUSH;
          cnt_d   = CNT_LOAD;
          cause_d = '0;
          eret_d  = 1'b1;
        end
      end
      EXU_RAISE: begin
        state_d = EXU_FLUSH;
        cnt_d   = CNT_LOAD;
      end
      EXU_FLUSH: begin
        if (cnt_q == '0) state_d = EXU_REDIRECT;
        else             cnt_d = cnt_q - CW'(1);
      end
      EXU_REDIRECT: begin
        state_d = EXU_IDLE;
      end
      default: begin
        state_d = EXU_IDLE;
      end
    endcase
  end

  // sequence state and captured exception record
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EXU_IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      epc_q   <= '0;
      bad_q   <= '0;
      eret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      bad_q   <= bad_d;
      eret_q  <= eret_d;
    end
  end

  // external pending flag and sticky double fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      df_q   <= 1'b0;
    end else begin
      pend_q <= take_ext ? 1'b0 : (pend_q | ext_s);
      df_q   <= df_q | drop;
    end
  end

  logic raise;
  assign raise = (state_q == EXU_RAISE);

  assign int_ext   = raise & cause_q.ext;
  assign int_tr    = raise & cause_q.tr;
  assign int_ovf   = raise & cause_q.ovf;
  assign int_ri    = raise & cause_q.ri;
  assign int_sys   = raise & cause_q.sys;
  assign int_addrs = raise & cause_q.addrs;
  assign int_addrl = raise & cause_q.addrl;

  assign epc_out        = epc_q;
  assign badvaddr_out   = bad_q;
  assign flush          = raise
                          | (state_q == EXU_FLUSH);
  assign redirect_valid = (state_q == EXU_REDIRECT);
  assign redirect_pc    = !redirect_valid ? '0
                          : eret_q ? epc_in
                          : HANDLER_ADDR;
  assign double_fault   = df_q;

endmodule

// File: tb/tb_exc_unit.sv
// tb_exc_unit: table vectors, random vs model,
// and hand sequences for ext/reset corners.
module tb_exc_unit;
  import exc_unit_pkg::*;

  localparam logic [31:0] HANDLER = 32'h8000_0180;
  localparam int K_NONE = 0;
  localparam int K_EXC  = 1;
  localparam int K_ERET = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ext_irq = 1'b0;
  logic id_ri = 1'b0, id_sys = 1'b0;
  logic ex_tr = 1'b0, ex_ovf = 1'b0;
  logic mem_addrs = 1'b0, mem_addrl = 1'b0;
  logic mem_eret = 1'b0, exc_level = 1'b0;
  logic [31:0] id_pc = '0, ex_pc = '0;
  logic [31:0] mem_pc = '0, mem_addr = '0;
  logic [31:0] epc_in = '0;
  logic int_ext, int_tr, int_ovf, int_ri;
  logic int_sys, int_addrs, int_addrl;
  logic [31:0] epc_out, badvaddr_out, redirect_pc;
  logic flush, redirect_valid, double_fault;

  int checks = 0;
  int failures = 0;

  exc_unit dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq),
    .id_ri(id_ri), .id_sys(id_sys), .id_pc(id_pc),
    .ex_tr(ex_tr), .ex_ovf(ex_ovf), .ex_pc(ex_pc),
    .mem_addrs(mem_addrs), .mem_addrl(mem_addrl),
    .mem_pc(mem_pc), .mem_addr(mem_addr),
    .mem_eret(mem_eret), .exc_level(exc_level),
    .epc_in(epc_in),
    .int_ext(int_ext), .int_tr(int_tr),
    .int_ovf(int_ovf), .int_ri(int_ri),
    .int_sys(int_sys), .int_addrs(int_addrs),
    .int_addrl(int_addrl),
    .epc_out(epc_out), .badvaddr_out(badvaddr_out),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // {ext,tr,ovf,ri,sys,addrs,addrl}
  function automatic logic [6:0] ints();
    return {int_ext, int_tr, int_ovf, int_ri,
            int_sys, int_addrs, int_addrl};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags: {addrs,addrl,eret,tr,ovf,ri,sys}
  task automatic drive(input logic [6:0] f,
                       input logic exl);
    {mem_addrs, mem_addrl, mem_eret, ex_tr,
     ex_ovf, id_ri, id_sys} = f;
    exc_level = exl;
  endtask

  // reference: first active flag in age order wins
  task automatic predict(
    input  logic [6:0]  f,
    input  logic        exl,
    output int          kind,
    output logic [6:0]  ie,
    output logic [31:0] pc,
    output logic [31:0] bad,
    output logic        dropped);
    logic [6:0] bit_of [7];
    logic [31:0] pc_of [7];
    int first;
    bit_of = '{7'b0000010, 7'b0000001, 7'b0,
               7'b0100000, 7'b0010000,
               7'b0001000, 7'b0000100};
    pc_of = '{mem_pc, mem_pc, mem_pc, ex_pc,
              ex_pc, id_pc, id_pc};
    first = -1;
    for (int i = 6; i >= 0; i--)
      if (f[6-i]) first = i;
    kind = K_NONE;
    ie = '0;
    pc = '0;
    bad = '0;
    dropped = 1'b0;
    if (first == 2) kind = K_ERET;
    else if (first >= 0 && exl) dropped = 1'b1;
    else if (first >= 0) begin
      kind = K_EXC;
      ie = bit_of[first];
      pc = pc_of[first];
      if (first < 2) bad = mem_addr;
    end
  endtask

  // apply one cycle of flags, then trace 8 cycles
  task automatic run_seq(
    input string      nm,
    input logic [6:0] f,
    input logic       exl,
    input int         kind,
    input logic [6:0] ie,
    input logic [31:0] pc,
    input logic [31:0] bad,
    input logic       df);
    logic [40:0] ev;
    drive(f, exl);
    tick();
    drive(7'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      ev = '0;
      if (kind == K_EXC) begin
        if (k == 1)      ev = {ie, 2'b10, 32'h0};
        else if (k <= 4) ev = {7'h0, 2'b10, 32'h0};
        else if (k == 5) ev = {7'h0, 2'b01, HANDLER};
      end else if (kind == K_ERET) begin
        if (k <= 3)      ev = {7'h0, 2'b10, 32'h0};
        else if (k == 4) ev = {7'h0, 2'b01, epc_in};
      end
      chk($sformatf("%s.k%0d", nm, k),
          {23'h0, ints(), flush,
           redirect_valid, redirect_pc},
          {23'h0, ev});
      if (kind == K_EXC && (k == 1 || k == 5)) begin
        chk({nm, ".epc"}, {32'h0, epc_out},
            {32'h0, pc});
        chk({nm, ".bad"}, {32'h0, badvaddr_out},
            {32'h0, bad});
      end
      if (k == 8)
        chk({nm, ".df"}, {63'h0, double_fault},
            {63'h0, df});
      tick();
    end
  endtask

  typedef struct {
    logic [6:0]  f;
    logic        exl;
    int          kind;
    logic [6:0]  ie;
    logic [31:0] pc;
    logic [31:0] bad;
    logic        df;
  } vec_t;

  vec_t tbl [10];

  task automatic chk_zero(input string nm);
    chk(nm, {ints(), flush, redirect_valid,
             double_fault, redirect_pc,
             epc_out[21:0] | badvaddr_out[21:0]
             | epc_out[31:10] | badvaddr_out[31:10]},
        64'h0);
  endtask

  initial begin
    logic df_m;
    int kind;
    logic [6:0] ie, f;
    logic [31:0] pc, bad;
    logic dr, exl, seen, bad_seen;
    exu_cause_t cc;

    tbl[0] = '{7'b0000100, 0, K_EXC, 7'b0010000,
               32'h0040_0010, 32'h0, 0};
    tbl[1] = '{7'b0101001, 0, K_EXC, 7'b0000001,
               32'h0040_0020, 32'h1001_0003, 0};
    tbl[2] = '{7'b0010100, 0, K_ERET, 7'b0,
               32'h0, 32'h0, 0};
    tbl[3] = '{7'b0000010, 1, K_NONE, 7'b0,
               32'h0, 32'h0, 1};
    tbl[4] = '{7'b1000000, 0, K_EXC, 7'b0000010,
               32'h0040_0020, 32'h1001_0003, 1};
    tbl[5] = '{7'b0001010, 0, K_EXC, 7'b0100000,
               32'h0040_0010, 32'h0, 1};
    tbl[6] = '{7'b0000001, 0, K_EXC, 7'b0000100,
               32'h0040_0008, 32'h0, 1};
    tbl[7] = '{7'b0010010, 1, K_ERET, 7'b0,
               32'h0, 32'h0, 1};
    tbl[8] = '{7'b0000000, 0, K_NONE, 7'b0,
               32'h0, 32'h0, 1};
    tbl[9] = '{7'b0000010, 0, K_EXC, 7'b0001000,
               32'h0040_0008, 32'h0, 1};

    #2;
    chk_zero("reset_state");
    tick();
    tick();
    reset = 1'b1;
    tick();

    id_pc = 32'h0040_0008;
    ex_pc = 32'h0040_0010;
    mem_pc = 32'h0040_0020;
    mem_addr = 32'h1001_0003;
    epc_in = 32'h0040_0100;
    for (int i = 0; i < 10; i++)
      run_seq($sformatf("tbl%0d", i), tbl[i].f,
              tbl[i].exl, tbl[i].kind, tbl[i].ie,
              tbl[i].pc, tbl[i].bad, tbl[i].df);

    df_m = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int b = 0; b < 7; b++)
        f[b] = ($urandom_range(0, 3) == 0);
      exl = ($urandom_range(0, 3) == 0);
      id_pc = $urandom & ~32'h3;
      ex_pc = $urandom & ~32'h3;
      mem_pc = $urandom & ~32'h3;
      mem_addr = $urandom;
      epc_in = $urandom & ~32'h3;
      predict(f, exl, kind, ie, pc, bad, dr);
      df_m = df_m | dr;
      run_seq($sformatf("rnd%0d", i), f, exl, kind,
              ie, pc, bad, df_m);
    end

    // ext held under EXL, taken once EXL drops
    mem_pc = 32'h0040_0044;
    exc_level = 1'b1;
    ext_irq = 1'b1;
    bad_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ints() != 0 || flush) bad_seen = 1'b1;
      tick();
    end
    chk("ext_held", {63'h0, bad_seen}, 64'h0);
    exc_level = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (ints() != 0) begin
        seen = 1'b1;
        cc = exu_cause_t'(ints());
        if (cause_code(cc) != INT_EXT)
          $display("FAIL ext_code got=%0d want=%0d",
                   cause_code(cc), INT_EXT);
        chk("ext_int", {57'h0, ints()},
            {57'h0, 7'b1000000});
        chk("ext_epc", {32'h0, epc_out},
            {32'h0, 32'h0040_0044});
        chk("ext_bad", {32'h0, badvaddr_out}, 64'h0);
        ext_irq = 1'b0;
        exc_level = 1'b1;
      end else tick();
    end
    chk("ext_taken", {63'h0, seen}, 64'h1);
    for (int c = 0; c < 10; c++) tick();

    // reset mid-sequence, then clean restart
    reset = 1'b0;
    #1;
    chk_zero("reset_mid");
    tick();
    reset = 1'b1;
    exc_level = 1'b0;
    tick();
    ex_pc = 32'h0040_0010;
    drive(7'b0000100, 1'b0);
    tick();
    drive(7'b0, 1'b0);
    tick();
    tick();
    chk("in_flush", {63'h0, flush}, 64'h1);
    reset = 1'b0;
    #1;
    chk_zero("reset_flush");
    tick();
    tick();
    reset = 1'b1;
    bad_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (ints() != 0 || flush || redirect_valid)
        bad_seen = 1'b1;
      tick();
    end
    chk("post_reset_quiet", {63'h0, bad_seen}, 64'h0);
    run_seq("post_reset_ovf", 7'b0000100, 1'b0,
            K_EXC, 7'b0010000, 32'h0040_0010,
            32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
